// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FQ_DEFAULT_DEPTH = 4;

  // One buffered fetch result: address, instruction word, and alignment flag.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of {pc, instr, misalign} between fetch and decode.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_pc/in_instr, in_ready, stll : fetch-side handshake and PC stall
//   flush                 : redirect, empties the queue
//   out_valid/out_pc/out_instr/out_misalign, out_ready : decode-side handshake
//   count                 : number of occupied entries
// Optional macro FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     in_ready,
  output logic                     stll,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_misalign,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  fetch_entry_t  mem [DEPTH];

  logic          empty_c;
  logic          full_c;
  logic          push_c;
  logic          pop_c;
  fetch_entry_t  in_entry_c;
  fetch_entry_t  head_c;

  // Extra pointer MSB separates full from empty when index bits match.
  assign empty_c = (rd_ptr == wr_ptr);
  assign full_c  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  assign in_entry_c = '{pc: in_pc, instr: in_instr, misalign: (in_pc[1:0] != 2'b00)};
  assign head_c     = mem[rd_ptr[AW-1:0]];

  assign in_ready = !full_c;
  assign stll     = full_c;
  assign count    = wr_ptr - rd_ptr;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_c;

  // Empty queue forwards the incoming pair; a consumed bypass is never stored.
  assign bypass_c     = empty_c && in_valid && !flush;
  assign out_valid    = !empty_c || bypass_c;
  assign out_pc       = bypass_c ? in_entry_c.pc       : head_c.pc;
  assign out_instr    = bypass_c ? in_entry_c.instr    : head_c.instr;
  assign out_misalign = bypass_c ? in_entry_c.misalign : head_c.misalign;
  assign push_c       = in_valid && !full_c && !flush && !(bypass_c && out_ready);
  assign pop_c        = !empty_c && out_ready && !flush;
`else
  assign out_valid    = !empty_c;
  assign out_pc       = head_c.pc;
  assign out_instr    = head_c.instr;
  assign out_misalign = head_c.misalign;
  assign push_c       = in_valid && !full_c && !flush;
  assign pop_c        = !empty_c && out_ready && !flush;
`endif

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is left uninitialised; stale contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= in_entry_c;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed stimulus with a scoreboard monitor.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            stll;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misalign;
  logic            out_ready;
  logic [2:0]      count;

  int checks = 0;
  int errors = 0;
  fetch_entry_t sb[$];

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .stll(stll), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_misalign(out_misalign), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  // Drive a pair for one cycle; if expected to be stored, record it.
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic rdy, input logic mis, input logic accept);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    if (accept) sb.push_back('{pc: pc, instr: instr, misalign: mis});
    step();
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
    idle();
  endtask

  // Monitor: every completed handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc 0x%08h, required no output", out_pc);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        check("pop_pc", out_pc, e.pc);
        check("pop_instr", out_instr, e.instr);
        check("pop_misalign", 32'(out_misalign), 32'(e.misalign));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_stll", 32'(stll), 32'd0);
    rst_n = 1'b1;
    step();

    // Two pushes, decode not ready.
    drive(32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1);
    drive(32'h0000_0004, 32'h0050_0093, 1'b0, 1'b0, 1'b1);
    idle();
    check("t1_count", 32'(count), 32'd2);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_pc", out_pc, 32'h0000_0000);
    check("t1_out_instr", out_instr, 32'h0000_0013);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    drain(2);
    check("t1_drained", 32'(count), 32'd0);

    // Fill to DEPTH, then push+pop while full: push refused.
    for (int i = 0; i < 4; i++)
      drive(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1);
    idle();
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_stll", 32'(stll), 32'd1);
    drive(32'h20, 32'hA4, 1'b1, 1'b0, 1'b0);
    idle();
    check("t2_count_after", 32'(count), 32'd3);
    drain(3);
    check("t2_drained", 32'(count), 32'd0);

    // Streaming push+pop across pointer wrap.
    drive(32'h100, 32'h1000, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      drive(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b1);
      check("t3_count", 32'(count), 32'd1);
    end
    drain(1);
    check("t3_drained", 32'(count), 32'd0);

    // Flush with concurrent push and pop.
    drive(32'h300, 32'h3000, 1'b0, 1'b0, 1'b1);
    drive(32'h304, 32'h3004, 1'b0, 1'b0, 1'b1);
    drive(32'h308, 32'h3008, 1'b0, 1'b0, 1'b1);
    idle();
    check("t4_count_pre", 32'(count), 32'd3);
    sb.delete();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h30C; in_instr = 32'h300C; out_ready = 1'b1;
    step();
    idle();
    check("t4_count", 32'(count), 32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    drive(32'h400, 32'h4000, 1'b0, 1'b0, 1'b1);
    idle();
    check("t4_count_post", 32'(count), 32'd1);
    check("t4_head_pc", out_pc, 32'h400);
    drain(1);

    // Misalign flag.
    drive(32'h102, 32'h5000, 1'b0, 1'b1, 1'b1);
    idle();
    check("t5_misalign_set", 32'(out_misalign), 32'd1);
    drive(32'h104, 32'h5004, 1'b0, 1'b0, 1'b1);
    idle();
    drain(2);

    // Reset asserted mid-operation.
    drive(32'h500, 32'h6000, 1'b0, 1'b0, 1'b0);
    drive(32'h504, 32'h6004, 1'b0, 1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    step();
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();

`ifdef FETCH_QUEUE_BYPASS_EN
    // Zero-latency bypass when empty and consumed immediately.
    sb.push_back('{pc: 32'h200, instr: 32'h7000, misalign: 1'b0});
    in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h7000; out_ready = 1'b1;
    #1;
    check("t7_byp_out_valid", 32'(out_valid), 32'd1);
    check("t7_byp_out_pc", out_pc, 32'h200);
    step();
    idle();
    check("t7_byp_count", 32'(count), 32'd0);
    check("t7_byp_out_valid_after", 32'(out_valid), 32'd0);
`endif

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
